t2mi_timestamp_packet_gen: RTL and testbench

Builds and transmits T2-MI timestamp packets (type 0x20) as a byte stream. Its output is the input side of the T2-MI packet parser and timestamp extractor. On each load request it latches a timestamp and serialises header, payload and CRC-32 with valid/ready flow control. It is used as the on-chip loopback source and as the generator in transmit-side builds.

---
 rtl/t2mi_pkg.sv | 59 +++++
 rtl/crc32_mpeg2_byte.sv | 18 +
 rtl/t2mi_timestamp_packet_gen.sv | 124 ++++++++++++
 tb/tb_t2mi_timestamp_packet_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/t2mi_pkg.sv
// Shared T2-MI constants, FSM state type and timestamp field layout.
// T2MI_TX_CRC_EN adds the CRC state and the 4 trailing CRC bytes.
package t2mi_pkg;

  localparam logic [7:0]  T2MI_TYPE_TIMESTAMP  = 8'h20;
  localparam logic [15:0] T2MI_TS_PAYLOAD_BITS = 16'd88;
  localparam int          T2MI_HDR_BYTES       = 6;
  localparam int          T2MI_TS_PAY_BYTES    = 11;
  localparam logic [31:0] CRC32_POLY           = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;

  localparam logic [4:0] T2MI_LAST_HDR = 5'(T2MI_HDR_BYTES - 1);
  localparam logic [4:0] T2MI_LAST_PAY = 5'(T2MI_HDR_BYTES + T2MI_TS_PAY_BYTES - 1);

`ifdef T2MI_TX_CRC_EN
  localparam logic [4:0] T2MI_LAST_BYTE = 5'(T2MI_LAST_PAY + 5'd4);
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_CRC} t2mi_state_e;
`else
  localparam logic [4:0] T2MI_LAST_BYTE = T2MI_LAST_PAY;
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY} t2mi_state_e;
`endif

  typedef struct packed {
    logic [39:0] seconds;
    logic [26:0] subsec;
    logic [12:0] utc;
    logic [3:0]  bw;
    logic [3:0]  sf;
  } ts_fields_t;

  // Header/payload byte at position idx (0..16) of a timestamp packet.
  function automatic logic [7:0] ts_byte(ts_fields_t f, logic [7:0] cnt, logic [4:0] idx);
    logic [39:0] p40;
    logic [7:0]  b;
    p40 = {f.subsec, f.utc};
    case (idx)
      5'd0:    b = T2MI_TYPE_TIMESTAMP;
      5'd1:    b = cnt;
      5'd2:    b = {f.sf, 4'h0};
      5'd3:    b = 8'h00;
      5'd4:    b = T2MI_TS_PAYLOAD_BITS[15:8];
      5'd5:    b = T2MI_TS_PAYLOAD_BITS[7:0];
      5'd6:    b = {4'h0, f.bw};
      5'd7:    b = f.seconds[39:32];
      5'd8:    b = f.seconds[31:24];
      5'd9:    b = f.seconds[23:16];
      5'd10:   b = f.seconds[15:8];
      5'd11:   b = f.seconds[7:0];
      5'd12:   b = p40[39:32];
      5'd13:   b = p40[31:24];
      5'd14:   b = p40[23:16];
      5'd15:   b = p40[15:8];
      5'd16:   b = p40[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/crc32_mpeg2_byte.sv
// One-byte step of CRC-32/MPEG-2 (MSB first, no reflection). Purely combinational.
module crc32_mpeg2_byte
  import t2mi_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (crc_out[31] ^ data[i]) crc_out = {crc_out[30:0], 1'b0} ^ CRC32_POLY;
      else                       crc_out = {crc_out[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/t2mi_timestamp_packet_gen.sv
// T2-MI timestamp packet (type 0x20) serialiser with valid/ready output.
// Build option: T2MI_TX_CRC_EN appends CRC-32/MPEG-2 (21-byte packets, else 17).
module t2mi_timestamp_packet_gen
  import t2mi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ts_load,
  input  logic [39:0] seconds_since_2000,
  input  logic [31:0] subseconds,
  input  logic [12:0] utc_offset,
  input  logic [3:0]  bandwidth_code,
  input  logic [3:0]  superframe_idx,
  input  logic        t2mi_ready,
  output logic        t2mi_valid,
  output logic [7:0]  t2mi_data,
  output logic        t2mi_sync,
  output logic        busy,
  output logic        pkt_done,
  output logic        ts_overrun,
  output logic [7:0]  packet_count
);

  t2mi_state_e state;
  ts_fields_t  fields;
  logic [4:0]  byte_idx;
  logic [4:0]  idx_nxt;
  logic [7:0]  next_byte;
  logic        accept;

  // Only the low 27 subsecond bits go on the wire.
  logic unused_subsec_hi;
  assign unused_subsec_hi = ^subseconds[31:27];

  assign accept = t2mi_valid && t2mi_ready;

`ifdef T2MI_TX_CRC_EN
  logic [31:0] crc_q;
  logic [31:0] crc_nxt;

  crc32_mpeg2_byte u_crc (
    .crc_in  (crc_q),
    .data    (t2mi_data),
    .crc_out (crc_nxt)
  );
`endif

  // Byte to present after the current one is accepted.
  always_comb begin
    idx_nxt   = byte_idx + 5'd1;
    next_byte = ts_byte(fields, packet_count, idx_nxt);
`ifdef T2MI_TX_CRC_EN
    // First CRC byte must already include byte 16, hence crc_nxt.
    case (idx_nxt)
      T2MI_LAST_PAY + 5'd1: next_byte = crc_nxt[31:24];
      T2MI_LAST_PAY + 5'd2: next_byte = crc_q[23:16];
      T2MI_LAST_PAY + 5'd3: next_byte = crc_q[15:8];
      T2MI_LAST_PAY + 5'd4: next_byte = crc_q[7:0];
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      fields       <= '0;
      byte_idx     <= 5'd0;
      t2mi_valid   <= 1'b0;
      t2mi_data    <= 8'h00;
      t2mi_sync    <= 1'b0;
      busy         <= 1'b0;
      pkt_done     <= 1'b0;
      ts_overrun   <= 1'b0;
      packet_count <= 8'h00;
`ifdef T2MI_TX_CRC_EN
      crc_q        <= CRC32_INIT;
`endif
    end else begin
      pkt_done   <= 1'b0;
      ts_overrun <= 1'b0;
      if (state == ST_IDLE) begin
        if (ts_load) begin
          fields     <= '{seconds: seconds_since_2000, subsec: subseconds[26:0],
                          utc: utc_offset, bw: bandwidth_code, sf: superframe_idx};
          byte_idx   <= 5'd0;
          t2mi_data  <= T2MI_TYPE_TIMESTAMP;
          t2mi_valid <= 1'b1;
          t2mi_sync  <= 1'b1;
          busy       <= 1'b1;
          state      <= ST_HDR;
`ifdef T2MI_TX_CRC_EN
          crc_q      <= CRC32_INIT;
`endif
        end
      end else begin
        if (ts_load) ts_overrun <= 1'b1;
        if (accept) begin
          t2mi_sync <= 1'b0;
`ifdef T2MI_TX_CRC_EN
          // CRC covers header+payload only; frozen while its own bytes go out.
          if (state != ST_CRC) crc_q <= crc_nxt;
`endif
          if (byte_idx == T2MI_LAST_BYTE) begin
            t2mi_valid   <= 1'b0;
            t2mi_data    <= 8'h00;
            busy         <= 1'b0;
            pkt_done     <= 1'b1;
            packet_count <= packet_count + 8'd1;
            state        <= ST_IDLE;
          end else begin
            byte_idx  <= idx_nxt;
            t2mi_data <= next_byte;
            if (byte_idx == T2MI_LAST_HDR) state <= ST_PAY;
`ifdef T2MI_TX_CRC_EN
            if (byte_idx == T2MI_LAST_PAY) state <= ST_CRC;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_t2mi_timestamp_packet_gen.sv
// Randomized bench for t2mi_timestamp_packet_gen against a byte-queue packet model.
module tb_t2mi_timestamp_packet_gen;

`ifdef T2MI_TX_CRC_EN
  localparam int PKT_LEN = 21;
`else
  localparam int PKT_LEN = 17;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ts_load = 1'b0;
  logic [39:0] sec = '0;
  logic [31:0] sub = '0;
  logic [12:0] utc = '0;
  logic [3:0]  bw = '0;
  logic [3:0]  sf = '0;
  logic        t2mi_ready = 1'b0;
  logic        t2mi_valid, t2mi_sync, busy, pkt_done, ts_overrun;
  logic [7:0]  t2mi_data, packet_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  t2mi_timestamp_packet_gen dut (
    .clk(clk), .rst_n(rst_n), .ts_load(ts_load),
    .seconds_since_2000(sec), .subseconds(sub), .utc_offset(utc),
    .bandwidth_code(bw), .superframe_idx(sf), .t2mi_ready(t2mi_ready),
    .t2mi_valid(t2mi_valid), .t2mi_data(t2mi_data), .t2mi_sync(t2mi_sync),
    .busy(busy), .pkt_done(pkt_done), .ts_overrun(ts_overrun),
    .packet_count(packet_count)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_of(bq_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i])
      for (int b = 7; b >= 0; b--)
        if (c[31] ^ q[i][b]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
        else                 c = {c[30:0], 1'b0};
    return c;
  endfunction

  function automatic bq_t build(logic [39:0] s, logic [31:0] ss, logic [12:0] u,
                                logic [3:0] b, logic [3:0] f, logic [7:0] cnt);
    bq_t q;
    logic [39:0] p;
`ifdef T2MI_TX_CRC_EN
    logic [31:0] c;
`endif
    p = {ss[26:0], u};
    q = '{8'h20, cnt, {f, 4'h0}, 8'h00, 8'h00, 8'h58, {4'h0, b}};
    for (int i = 4; i >= 0; i--) q.push_back(s[i*8 +: 8]);
    for (int i = 4; i >= 0; i--) q.push_back(p[i*8 +: 8]);
`ifdef T2MI_TX_CRC_EN
    c = crc_of(q);
    for (int i = 3; i >= 0; i--) q.push_back(c[i*8 +: 8]);
`endif
    return q;
  endfunction

  // Model: remaining bytes of the packet in flight, plus pulse/counter state.
  bq_t        m_q;
  int         m_pos = 0;
  logic [7:0] m_count = 8'h00;
  logic       m_done = 1'b0;
  logic       m_ovr = 1'b0;
  bq_t        cap;
  int         n_ovr_seen = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_q.delete(); m_pos = 0; m_count = 8'h00; m_done = 1'b0; m_ovr = 1'b0;
    end
    chk("valid", t2mi_valid, m_q.size() != 0);
    chk("busy", busy, m_q.size() != 0);
    chk("sync", t2mi_sync, m_q.size() != 0 && m_pos == 0);
    if (m_q.size() != 0) chk("data", t2mi_data, m_q[0]);
    chk("pkt_done", pkt_done, m_done);
    chk("ts_overrun", ts_overrun, m_ovr);
    chk("packet_count", packet_count, m_count);
    if (t2mi_valid && t2mi_ready) cap.push_back(t2mi_data);
    if (ts_overrun) n_ovr_seen++;
    m_done = 1'b0;
    m_ovr  = 1'b0;
    if (rst_n) begin
      if (m_q.size() != 0) begin
        if (ts_load) m_ovr = 1'b1;
        if (t2mi_ready) begin
          void'(m_q.pop_front());
          m_pos++;
          if (m_q.size() == 0) begin m_done = 1'b1; m_count++; end
        end
      end else if (ts_load) begin
        m_q = build(sec, sub, utc, bw, sf, m_count);
        m_pos = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    sec = {8'($urandom), $urandom};
    sub = $urandom;
    utc = 13'($urandom);
    bw  = 4'($urandom);
    sf  = 4'($urandom);
  endtask

  task automatic wait_idle(int max, bit bp);
    for (int i = 0; i < max; i++) begin
      if (m_q.size() == 0) return;
      rand_fields();
      if (bp) t2mi_ready = 1'($urandom_range(0, 1));
      tick();
    end
    n_chk++; n_fail++;
    $display("FAIL wait_idle: still busy after %0d cycles", max);
  endtask

  task automatic send(bit bp);
    ts_load = 1'b1;
    tick();
    ts_load = 1'b0;
    wait_idle(400, bp);
    t2mi_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_valid"}, t2mi_valid, 0);
    chk({tag, "_data"}, t2mi_data, 8'h00);
    chk({tag, "_sync"}, t2mi_sync, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, pkt_done, 0);
    chk({tag, "_ovr"}, ts_overrun, 0);
    chk({tag, "_count"}, packet_count, 8'h00);
  endtask

  logic [7:0] exp1 [17] = '{8'h20, 8'h00, 8'h50, 8'h00, 8'h00, 8'h58, 8'h03, 8'h00, 8'h12,
                            8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h20, 8'h25};

  initial begin
    bq_t nine, ref1;
    int cyc, ovr0;
    logic [7:0] cnt0;

    #1 rst_n = 1'b0;
    t2mi_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Pin the model: standard CRC-32/MPEG-2 check value and the literal packet.
    nine = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_check", crc_of(nine), 32'h0376E6E7);
    ref1 = build(40'h00_1234_5678, 32'h1, 13'd37, 4'h3, 4'h5, 8'h00);
    for (int i = 0; i < 17; i++) chk("model_bytes", ref1[i], exp1[i]);

    // Basic packet, free flow
    sec = 40'h00_1234_5678; sub = 32'h1; utc = 13'd37; bw = 4'h3; sf = 4'h5;
    cap.delete();
    ts_load = 1'b1;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      ts_load = 1'b0;
      cyc++;
      if (pkt_done) break;
    end
    chk("done_latency", cyc, PKT_LEN + 1);
    chk("basic_len", cap.size(), PKT_LEN);
    for (int i = 0; i < 17; i++) chk("basic_byte", i < cap.size() ? cap[i] : 8'hxx, exp1[i]);
    tick();

    // Backpressure with inputs changing during the packet
    for (int p = 0; p < 4; p++) begin
      rand_fields();
      cap.delete();
      send(1'b1);
      chk("bp_len", cap.size(), PKT_LEN);
    end

    // Overrun at bytes 3 and 15
    rand_fields();
    ovr0 = n_ovr_seen;
    cnt0 = m_count;
    ts_load = 1'b1; tick(); ts_load = 1'b0;
    repeat (3) tick();
    ts_load = 1'b1; tick(); ts_load = 1'b0;
    repeat (11) tick();
    ts_load = 1'b1; tick(); ts_load = 1'b0;
    wait_idle(100, 1'b0);
    tick();
    chk("overrun_pulses", n_ovr_seen - ovr0, 2);
    chk("overrun_count", packet_count, 8'(cnt0 + 8'd1));

    // Reset at byte 9
    rand_fields();
    ts_load = 1'b1; tick(); ts_load = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    tick();
    rand_fields();
    cap.delete();
    send(1'b0);
    chk("midrst_hdr1", cap.size() > 1 ? cap[1] : 8'hxx, 8'h00);
    chk("midrst_len", cap.size(), PKT_LEN);

    // Counter wrap over 257 packets
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int p = 0; p < 256; p++) begin rand_fields(); send(1'b0); end
    rand_fields();
    cap.delete();
    send(1'b0);
    tick();
    chk("wrap_hdr1", cap.size() > 1 ? cap[1] : 8'hxx, 8'h00);
    chk("wrap_count", packet_count, 8'h01);

    // Random traffic: loads, overruns and backpressure mixed
    for (int i = 0; i < 3000; i++) begin
      rand_fields();
      ts_load = ($urandom_range(0, 15) == 0);
      t2mi_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    ts_load = 1'b0;
    t2mi_ready = 1'b1;
    wait_idle(100, 1'b0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
